// File: rtl/jam_cost_server_pkg.sv
// Shared types and constants for the assignment-engine cost server.
package jam_cost_server_pkg;

    localparam int TABLE_DEPTH = 64;
    localparam int COST_W      = 7;
    localparam int ADDR_W      = $clog2(TABLE_DEPTH);
    localparam int IDX_W       = 3;
    localparam int MIN_W       = 10;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SERVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Engine result and its expected counterpart share one shape.
    typedef struct packed {
        logic [MIN_W-1:0] min_cost;
        logic [CNT_W-1:0] match_cnt;
    } jam_result_t;

    function automatic logic result_match(input jam_result_t got, input jam_result_t exp);
        return (got.min_cost == exp.min_cost) && (got.match_cnt == exp.match_cnt);
    endfunction

endpackage

// File: rtl/jam_cost_server_if.sv
// Load bus and assignment-engine lookup/result signals.
interface jam_cost_server_if;
    import jam_cost_server_pkg::*;

    logic                     LD_VALID;
    logic [COST_W-1:0]        LD_DATA;
    logic                     LD_READY;
    logic [IDX_W-1:0]         W;
    logic [IDX_W-1:0]         J;
    logic [COST_W-1:0]        Cost;
    logic                     JAM_VALID;
    logic [MIN_W-1:0]         MinCost;
    logic [CNT_W-1:0]         MatchCount;
    logic [MIN_W-1:0]         EXP_MIN;
    logic [CNT_W-1:0]         EXP_CNT;

    // Driven by the loader / assignment engine side.
    modport master (
        output LD_VALID, LD_DATA, W, J, JAM_VALID, MinCost, MatchCount, EXP_MIN, EXP_CNT,
        input  LD_READY, Cost
    );

    // Driven by the cost server.
    modport slave (
        input  LD_VALID, LD_DATA, W, J, JAM_VALID, MinCost, MatchCount, EXP_MIN, EXP_CNT,
        output LD_READY, Cost
    );

endinterface

// File: rtl/jam_cost_table.sv
// 64x7 cost register file: synchronous write, registered read with clear.
module jam_cost_table
    import jam_cost_server_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COST_W-1:0] rd_data
);

    logic [TABLE_DEPTH-1:0][COST_W-1:0] mem;

    // Storage; reset wipes every entry so a partial load never survives.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    // Read register: cleared on request, refreshed when enabled, else holds.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rd_data <= '0;
        else if (rd_clr)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[raddr];
    end

endmodule

// File: rtl/jam_cost_server.sv
// Cost server: loads a 64-entry table, serves lookups, then checks the
// engine result against the expected values and latches pass/fail.
module jam_cost_server
    import jam_cost_server_pkg::*;
#(
    parameter int CYC_W = 20
) (
    input  logic             CLK,
    input  logic             RST,
    jam_cost_server_if.slave bus,
    output logic             TableReady,
    output logic             Done,
    output logic             Pass,
    output logic [CYC_W-1:0] CycleCount
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              ld_ready;
    logic              table_ready;
    logic              done;
    logic              ld_fire;
    logic              last_word;
    logic [COST_W-1:0] cost_q;

    assign ld_fire   = bus.LD_VALID && ld_ready;
    assign last_word = (addr_q == ADDR_W'(TABLE_DEPTH - 1));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // Next-state logic; FINISH only leaves via reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (ld_fire && last_word) state_d = SERVE;
            SERVE:   if (bus.JAM_VALID)        state_d = CHECK;
            CHECK:   state_d = FINISH;
            FINISH:  state_d = FINISH;
            default: state_d = LOAD;
        endcase
    end

    // Output decodes of the registered state.
    always_comb begin
        ld_ready    = (state_q == LOAD);
        table_ready = (state_q == SERVE);
        done        = (state_q == FINISH);
    end

    assign bus.LD_READY = ld_ready;
    assign TableReady   = table_ready;
    assign Done         = done;
    assign bus.Cost     = cost_q;

    // Load address; wraps to 0 after the final word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            addr_q <= '0;
        else if (ld_fire)
            addr_q <= addr_q + 1'b1;
    end

    jam_cost_table u_table (
        .CLK     (CLK),
        .RST     (RST),
        .we      (ld_fire),
        .waddr   (addr_q),
        .wdata   (bus.LD_DATA),
        .rd_en   (state_q == SERVE),
        .rd_clr  (state_q == LOAD),
        .raddr   ({bus.W, bus.J}),
        .rd_data (cost_q)
    );

    // Saturating count of cycles spent in SERVE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            CycleCount <= '0;
        else if (state_q == SERVE && CycleCount != {CYC_W{1'b1}})
            CycleCount <= CycleCount + 1'b1;
    end

    // Verdict captured once in CHECK, then held through FINISH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            Pass <= 1'b0;
        else if (state_q == CHECK)
            Pass <= result_match(jam_result_t'{bus.MinCost, bus.MatchCount},
                                 jam_result_t'{bus.EXP_MIN, bus.EXP_CNT});
    end

endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: stimulus queues expected lookups and
// verdicts, monitors pop and compare when the DUT presents them.
module tb_jam_cost_server;

    localparam int CYC_W = 4;

    logic             CLK;
    logic             RST;
    logic             TableReady;
    logic             Done;
    logic             Pass;
    logic [CYC_W-1:0] CycleCount;

    jam_cost_server_if bus();

    jam_cost_server #(.CYC_W(CYC_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .TableReady (TableReady),
        .Done       (Done),
        .Pass       (Pass),
        .CycleCount (CycleCount)
    );

    int checks   = 0;
    int failures = 0;

    int  exp_cost_q[$];
    int  exp_pass_q[$];
    bit  rd_issue = 0;
    bit  rd_due   = 0;
    bit  done_seen = 0;
    logic [6:0] pat [64];
    int  ncyc;

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Lookup monitor: a read issued one cycle earlier is due now.
    initial forever begin
        @(posedge CLK);
        rd_due = rd_issue;
    end

    initial forever begin
        @(negedge CLK);
        if (rd_due) begin
            if (exp_cost_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL cost_underflow: got %0d expected none", int'(bus.Cost));
            end else begin
                chk("cost", int'(bus.Cost), exp_cost_q.pop_front());
            end
        end
    end

    // Verdict monitor: compares Pass once per Done rising.
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            done_seen = 0;
        end else if (Done && !done_seen) begin
            done_seen = 1;
            if (exp_pass_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL pass_underflow: got %0d expected none", int'(Pass));
            end else begin
                chk("pass", int'(Pass), exp_pass_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        rd_issue       = 0;
        bus.LD_VALID   = 0;
        bus.JAM_VALID  = 0;
        RST            = 1;
        step(2);
        chk("rst_ld_ready", int'(bus.LD_READY), 1);
        chk("rst_table_ready", int'(TableReady), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_pass", int'(Pass), 0);
        chk("rst_cost", int'(bus.Cost), 0);
        chk("rst_cycles", int'(CycleCount), 0);
        RST = 0;
        step(1);
    endtask

    task automatic load_table(input bit toggle, input int nwords);
        ncyc = 0;
        for (int i = 0; i < nwords; i++) begin
            if (toggle) begin
                bus.LD_VALID = 0;
                step(1);
                ncyc++;
            end
            if (i == 63) chk("table_ready_before_last", int'(TableReady), 0);
            bus.LD_VALID = 1;
            bus.LD_DATA  = pat[i];
            step(1);
            ncyc++;
        end
        bus.LD_VALID = 0;
    endtask

    task automatic rd(input int w, input int j, input int exp);
        bus.W    = 3'(w);
        bus.J    = 3'(j);
        rd_issue = 1;
        exp_cost_q.push_back(exp);
        step(1);
        rd_issue = 0;
    endtask

    task automatic jam(input int mc, input int cnt, input int emin, input int ecnt);
        bus.MinCost    = 10'(mc);
        bus.MatchCount = 4'(cnt);
        bus.EXP_MIN    = 10'(emin);
        bus.EXP_CNT    = 4'(ecnt);
        bus.JAM_VALID  = 1;
        step(1);
        bus.JAM_VALID  = 0;
    endtask

    initial begin
        RST = 1;
        bus.LD_VALID = 0; bus.LD_DATA = 0; bus.W = 0; bus.J = 0;
        bus.JAM_VALID = 0; bus.MinCost = 0; bus.MatchCount = 0;
        bus.EXP_MIN = 0; bus.EXP_CNT = 0;

        // Contiguous load of i%8, lookups, passing verdict.
        do_reset();
        for (int i = 0; i < 64; i++) pat[i] = 7'(i % 8);
        load_table(0, 64);
        chk("t1_load_cycles", ncyc, 64);
        chk("t1_table_ready", int'(TableReady), 1);
        chk("t1_ld_ready_off", int'(bus.LD_READY), 0);
        chk("t1_cycles_start", int'(CycleCount), 0);
        chk("t1_cost_zero", int'(bus.Cost), 0);
        rd(3, 5, 5);
        rd(7, 7, 7);
        chk("t1_cycles_2", int'(CycleCount), 2);
        exp_pass_q.push_back(1);
        jam(16, 1, 16, 1);
        chk("t1_check_done", int'(Done), 0);
        chk("t1_check_tr", int'(TableReady), 0);
        step(1);
        chk("t1_finish_done", int'(Done), 1);
        chk("t1_cycles_hold", int'(CycleCount), 3);
        step(3);
        chk("t1_done_hold", int'(Done), 1);
        chk("t1_cost_hold", int'(bus.Cost), 7);
        chk("t1_pass_hold", int'(Pass), 1);

        // Toggled load of distinct values, full readback, failing verdict.
        do_reset();
        for (int i = 0; i < 64; i++) pat[i] = 7'((i * 37 + 5) % 128);
        load_table(1, 64);
        chk("t2_load_cycles", ncyc, 128);
        chk("t2_table_ready", int'(TableReady), 1);
        bus.LD_VALID = 1;
        bus.LD_DATA  = 7'h55;
        for (int i = 0; i < 64; i++) rd(i / 8, i % 8, int'(pat[i]));
        rd(0, 0, int'(pat[0]));
        bus.LD_VALID = 0;
        chk("t2_cycles_sat", int'(CycleCount), 15);
        exp_pass_q.push_back(0);
        jam(16, 2, 16, 1);
        step(1);
        chk("t2_done", int'(Done), 1);
        jam(16, 1, 16, 1);
        step(2);
        chk("t2_done_hold", int'(Done), 1);
        chk("t2_pass_hold", int'(Pass), 0);
        chk("t2_cycles_hold", int'(CycleCount), 15);

        // Reset mid-load, then full reload of 0x7F.
        do_reset();
        for (int i = 0; i < 64; i++) pat[i] = 7'd1;
        load_table(0, 30);
        do_reset();
        for (int i = 0; i < 64; i++) pat[i] = 7'h7F;
        load_table(0, 64);
        chk("t3_table_ready", int'(TableReady), 1);
        chk("t3_cycles_start", int'(CycleCount), 0);
        rd(0, 0, 127);
        rd(5, 2, 127);
        step(2);
        chk("t3_cycles", int'(CycleCount), 4);

        chk("cost_queue_drained", exp_cost_q.size(), 0);
        chk("pass_queue_drained", exp_pass_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jam_cost_server.md
JAM_COST_SERVER -- requirements
Module: jam_cost_server

Interface
REQ-001 Parameter CYC_W, default 20: width of the cycle counter.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 LD_VALID  input  1  cost-table load word valid.
REQ-005 LD_DATA  input  7  cost-table load word, row-major, index = W*8+J.
REQ-006 LD_READY  output  1  table accepts a load word.
REQ-007 W  input  3  worker index from the assignment engine.
REQ-008 J  input  3  job index from the assignment engine.
REQ-009 Cost  output  7  cost of (W,J) presented in the previous cycle.
REQ-010 JAM_VALID  input  1  assignment engine result valid.
REQ-011 MinCost  input  10  engine minimum cost result.
REQ-012 MatchCount  input  4  engine count of minimum-cost assignments.
REQ-013 EXP_MIN  input  10  expected minimum cost, sampled in CHECK.
REQ-014 EXP_CNT  input  4  expected match count, sampled in CHECK.
REQ-015 TableReady  output  1  high while in SERVE.
REQ-016 Done  output  1  high in FINISH.
REQ-017 Pass  output  1  comparison result, meaningful only while Done=1.
REQ-018 CycleCount  output  CYC_W  SERVE cycles elapsed, saturating.

Function
REQ-019 The FSM SHALL have four states: LOAD, SERVE, CHECK, FINISH.
REQ-020 LOAD: LD_READY=1; a word is accepted when LD_VALID=1 and LD_READY=1, written to table[addr], and the 6-bit addr increments.
REQ-021 Accepting the word at addr=63 SHALL transition LOAD->SERVE; addr wraps to 0.
REQ-022 LD_VALID=0 in LOAD SHALL hold addr; LD_READY SHALL be 0 outside LOAD, and words offered outside LOAD are ignored.
REQ-023 SERVE: Cost SHALL be registered as table[{W,J}], 1-cycle latency, updated every cycle.
REQ-024 Cost SHALL be 0 in LOAD; in CHECK and FINISH it holds its last value.
REQ-025 CycleCount SHALL increment each SERVE cycle and saturate at 2^CYC_W-1.
REQ-026 JAM_VALID=1 in SERVE SHALL transition to CHECK; JAM_VALID in LOAD is ignored.
REQ-027 CHECK (1 cycle): Pass <= (MinCost==EXP_MIN) && (MatchCount==EXP_CNT); then go to FINISH.
REQ-028 FINISH SHALL be terminal until RST; Done=1, and Pass, Cost and CycleCount hold.
REQ-029 Table entries are 7-bit unsigned; there are no arithmetic operations on costs.

Reset
REQ-030 RST SHALL force state=LOAD, addr=0, all 64 table entries=0, Cost=0, CycleCount=0, Pass=0, Done=0, TableReady=0, LD_READY=1 (after release).
REQ-031 RST asserted mid-load or mid-serve SHALL discard the partial table; a full 64-word reload is required.

Structure
REQ-032 A shared package SHALL hold the state encoding (LOAD=0, SERVE=1, CHECK=2, FINISH=3), TABLE_DEPTH=64 and COST_W=7.
REQ-033 One sub-module, jam_cost_table (64x7 register file, synchronous write, registered read), SHALL be instantiated.
REQ-034 All outputs SHALL be driven from registers or from decodes of the registered state.

Verification
REQ-035 Load 64 words with table[i]=i%8 and LD_VALID held high -> TableReady rises the cycle after word 63; LD_READY=0 from then on.
REQ-036 In SERVE, drive W=3,J=5 then W=7,J=7 -> Cost=5 one cycle later, then 7 the next cycle.
REQ-037 Toggle LD_VALID every other cycle during load -> 128 cycles to SERVE; every table entry reads back correctly.
REQ-038 EXP_MIN=10'd16, EXP_CNT=4'd1, JAM_VALID pulse with MinCost=16, MatchCount=1 -> Done=1 after 2 cycles, Pass=1.
REQ-039 Same sequence with MatchCount=2 -> Done=1, Pass=0; a later JAM_VALID is ignored.
REQ-040 Assert RST after 30 load words, then reload 64 words of 7'h7F -> W=0,J=0 reads 127; CycleCount restarts at 0.
